// File: rtl/uart8_receiver_if.sv
`timescale 1ns/1ps
// Receiver-side signal bundle: enable and serial line in, received byte and strobes out.
interface uart8_receiver_if;
    logic       en;
    logic       in;
    logic [7:0] out;
    logic       done;
    logic       err;
    logic       busy;

    modport master (
        output en,
        output in,
        input  out,
        input  done,
        input  err,
        input  busy
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output done,
        output err,
        output busy
    );
endinterface

// File: rtl/uart8_receiver.sv
`timescale 1ns/1ps
// 8N1 UART receiver on an oversampled clock: 2-flop rx synchroniser, start bit validated
// at mid-bit, data/stop sampled at mid-bit, one-cycle done/err strobes.
module uart8_receiver #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic             clk,
    input logic             rst_n,
    uart8_receiver_if.slave rx_if
);
    localparam int unsigned     CntW    = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic            armed_q, armed_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      out_q, out_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            cnt_half, cnt_full;

    // Synchroniser keeps running regardless of en; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_if.in};
        end
    end

    assign rx_s     = sync_q[1];
    assign cnt_half = (cnt_q == CntHalf);
    assign cnt_full = (cnt_q == CntFull);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q + CntW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Arming only on a high line stops a stuck-low line from retriggering.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = StStart;
                    armed_d = 1'b0;
                end
            end
            StStart: begin
                if (cnt_half) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_full) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                // Leaving mid-stop-bit lets a back-to-back start bit be caught.
                if (cnt_full) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (!rx_if.en) begin
            state_d = StIdle;
            armed_d = 1'b0;
            cnt_d   = '0;
            bit_d   = '0;
        end
    end

    always_comb begin
        out_d  = out_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        busy_d = busy_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
            end
            StStart: begin
                if (cnt_half && !rx_s) begin
                    busy_d = 1'b1;
                end
            end
            StData: begin
                busy_d = 1'b1;
            end
            StStop: begin
                if (cnt_full) begin
                    busy_d = 1'b0;
                    if (rx_s) begin
                        out_d  = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase

        if (!rx_if.en) begin
            out_d  = out_q;
            done_d = 1'b0;
            err_d  = 1'b0;
            busy_d = 1'b0;
        end
    end

    assign rx_if.out  = out_q;
    assign rx_if.done = done_q;
    assign rx_if.err  = err_q;
    assign rx_if.busy = busy_q;

endmodule
